fountain_uart: RTL and testbench
================================

# fountain_uart

Full-duplex 8N1 UART physical layer between the FPGA's serial pins and the byte-level command/response engine. Deserialises the `rx` pin into single-cycle byte strobes and serialises bytes presented with a `new_tx_data`/`tx_busy` handshake onto the `tx` pin. The handshake is tuned so a registered upstream producer can never lose a byte.

## Interface
Parameters:
- `CLK_PER_BIT`, default 50 — clock cycles per bit; 50 MHz / 1 Mbaud; legal range ≥ 4.
- `CTR_SIZE`, default `$clog2(CLK_PER_BIT)` — width of the bit-timing counters.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset; synchronous, active-high.
- `rx` in 1 — asynchronous serial input pin; idles high.
- `tx` out 1 — serial output pin; idles high.
- `block` in 1 — holds off new transmissions while high.
- `tx_data` in 8 — byte to send; sampled on accept.
- `new_tx_data` in 1 — request to send `tx_data`.
- `tx_busy` out 1 — transmitter cannot accept a byte.
- `rx_data` out 8 — last received byte; holds until the next byte.
- `new_rx_data` out 1 — one-cycle strobe: `rx_data` updated.
- `framing_err` out 1 — one-cycle strobe on a bad stop bit; present only with `UART_FRAMING_ERR_EN`.

## Operation
Receiver, `rx` path:
- `rx` passes through a 2-flop synchroniser; its reset value is 1.
- IDLE: synchronised `rx` low → START, counter = 0.
- START: at count `CLK_PER_BIT/2 - 1` (mid start bit):
  - `rx` still low → DATA, bit = 0, counter = 0.
  - `rx` high → IDLE (glitch reject; no strobe).
- DATA: every `CLK_PER_BIT` cycles, sample `rx` into a shift register, LSB first. After bit 7 → STOP.
- STOP: after `CLK_PER_BIT` cycles (mid stop bit), latch the shift register into `rx_data` and pulse `new_rx_data` for 1 cycle → IDLE.

Transmitter:
- IDLE: if `new_tx_data` and not `block`, latch `tx_data` → START.
  - `new_tx_data` while `block` is high is ignored, not queued.
- START: `tx` = 0 for `CLK_PER_BIT` cycles.
- DATA: 8 bits LSB first, `CLK_PER_BIT` cycles each.
- STOP: `tx` = 1 for `CLK_PER_BIT` cycles → IDLE.
- `tx` is registered.
- `tx_busy` = (tx state ≠ IDLE) | `block` | (`new_tx_data` & tx state == IDLE). This is combinational so that a producer sampling `tx_busy` in the accept cycle already sees busy.

Boundaries:
- Back-to-back transmit: a request in the first IDLE cycle after STOP is accepted, giving exactly 1 idle-high cycle between frames.
- Receive overrun: `rx_data` is simply overwritten; there is no flag.
- Simultaneous RX and TX are fully independent.
- Reset mid-frame: at the next edge all FSMs go to IDLE, `tx` = 1, and no strobe is emitted for the partial frame.

## Timing
- Reset values: `tx` = 1, `tx_busy` = `block`, `rx_data` = 0x00, `new_rx_data` = 0, `framing_err` = 0.
- TX: accept at edge N; `tx` falls in cycle N+1; the frame occupies 10·`CLK_PER_BIT` cycles.
  - The FSM returns to IDLE at N + 10·`CLK_PER_BIT` + 1.
- RX: `new_rx_data` rises 2 (sync) + `CLK_PER_BIT/2` + 9·`CLK_PER_BIT` cycles (±1) after the falling start edge on the pin.
- Counter arithmetic: `CTR_SIZE` unsigned, compared against `CLK_PER_BIT - 1`, never wraps.

## Configuration
`UART_FRAMING_ERR_EN`:
- Defined:
  - A low stop-bit sample pulses `framing_err` for 1 cycle.
  - `new_rx_data` is suppressed and `rx_data` is left unchanged.
  - The receiver waits for `rx` high before re-entering IDLE.
- Undefined: there is no `framing_err` port, and the byte is delivered regardless of the stop-bit value.

## Structure
- Package `fountain_uart_pkg` holds:
  - the shared 2-bit state encoding: IDLE = 0, START = 1, DATA = 2, STOP = 3;
  - the default `CLK_PER_BIT` constant.
- Sub-module `fountain_uart_rx` holds the synchroniser and receive FSM.
- The transmit FSM is inline in `fountain_uart`.

## Test plan
- TX, `CLK_PER_BIT` = 50: `tx_data` = 0xA5 with a 1-cycle request → `tx` = 0 for 50 cycles, then bits 1,0,1,0,0,1,0,1 at 50 cycles each, then 1.
  - `tx_busy` is high in the request cycle and low 501 cycles later.
- RX: a bench-driven 0x3C frame → exactly one `new_rx_data` pulse, `rx_data` = 0x3C, timing within the window above.
- Glitch: `rx` low for 10 cycles → no strobe; a 0x55 frame sent afterwards is received correctly.
- Handshake: a producer that asserts `new_tx_data` whenever `tx_busy` was low the prior cycle, sending 0x01, 0x02, 0x03 → exactly 3 frames, in order, each separated by 1 idle cycle.
  - Hold `block` high for 1000 cycles → no frame while blocked.
- Stop bit low on 0x7E:
  - with `UART_FRAMING_ERR_EN` → `framing_err` pulse, no `new_rx_data`;
  - without it → `rx_data` = 0x7E is delivered.
- Assert `rst` mid-TX frame (bit 4) → `tx` = 1 the next cycle; `tx_busy` low once `rst` deasserts.

Source files
------------

// File: rtl/fountain_uart_pkg.sv
// Shared definitions for the fountain_uart 8N1 physical layer: the state
// encoding used by both the receive and transmit FSMs and the default bit time.
package fountain_uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 50;
  localparam int DATA_BITS           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/fountain_uart_rx.sv
// Receive half of fountain_uart: 2-flop synchroniser plus 8N1 deserialiser.
// With UART_FRAMING_ERR_EN defined, a low stop bit raises framing_err instead of delivering.
module fountain_uart_rx
  import fountain_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data
`ifdef UART_FRAMING_ERR_EN
  ,
  output logic       framing_err
`endif
);

  localparam logic [CTR_SIZE-1:0] BIT_END  = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] HALF_END = CTR_SIZE'(CLK_PER_BIT / 2 - 1);

  logic                rx_meta_q, rx_sync_q;
  uart_state_e         state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                strobe_q, strobe_d;
`ifdef UART_FRAMING_ERR_EN
  logic                err_q, err_d;
  logic                wait_high_q, wait_high_d;
`endif

  // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
`ifdef UART_FRAMING_ERR_EN
      err_q       <= 1'b0;
      wait_high_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
`ifdef UART_FRAMING_ERR_EN
      err_q       <= err_d;
      wait_high_q <= wait_high_d;
`endif
    end
  end

  // NOTE: the shift register is fully refilled before each use, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    strobe_d = 1'b0;
`ifdef UART_FRAMING_ERR_EN
    err_d       = 1'b0;
    wait_high_d = wait_high_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          ctr_d   = '0;
        end
      end
      ST_START: begin
        // Re-check the line mid start bit to reject short glitches.
        if (ctr_q == HALF_END) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (ctr_q == BIT_END) begin
          ctr_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_STOP: begin
`ifdef UART_FRAMING_ERR_EN
        if (wait_high_q) begin
          // Hold here after a bad stop bit until the line idles again.
          if (rx_sync_q) begin
            wait_high_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (ctr_q == BIT_END) begin
          ctr_d = '0;
          if (rx_sync_q) begin
            data_d   = shift_q;
            strobe_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            err_d       = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
`else
        if (ctr_q == BIT_END) begin
          ctr_d    = '0;
          data_d   = shift_q;
          strobe_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign new_rx_data = strobe_q;
`ifdef UART_FRAMING_ERR_EN
  assign framing_err = err_q;
`endif

endmodule

// File: rtl/fountain_uart.sv
// Full-duplex 8N1 UART: inline transmit FSM plus the fountain_uart_rx receiver.
// Optional macro UART_FRAMING_ERR_EN adds the framing_err strobe port.
module fountain_uart
  import fountain_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       block,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       new_rx_data
`ifdef UART_FRAMING_ERR_EN
  ,
  output logic       framing_err
`endif
);

  localparam logic [CTR_SIZE-1:0] BIT_END = CTR_SIZE'(CLK_PER_BIT - 1);

  uart_state_e         tx_state_q, tx_state_d;
  logic [CTR_SIZE-1:0] tx_ctr_q, tx_ctr_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic                tx_q, tx_d;

  fountain_uart_rx #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CTR_SIZE    (CTR_SIZE)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data)
`ifdef UART_FRAMING_ERR_EN
    ,
    .framing_err (framing_err)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_ctr_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_ctr_q   <= tx_ctr_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the pin level for the state being entered, so the pin tracks the FSM with no lag.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_ctr_d   = tx_ctr_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (new_tx_data && !block) begin
          tx_state_d = ST_START;
          tx_ctr_d   = '0;
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tx_ctr_q == BIT_END) begin
          tx_ctr_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_ctr_d = tx_ctr_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_ctr_q == BIT_END) begin
          tx_ctr_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_ctr_d = tx_ctr_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_ctr_q == BIT_END) begin
          tx_ctr_d   = '0;
          tx_state_d = ST_IDLE;
          tx_d       = 1'b1;
        end else begin
          tx_ctr_d = tx_ctr_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  assign tx = tx_q;

  // Combinational so a producer already sees busy in the cycle its request is accepted.
  assign tx_busy = (tx_state_q != ST_IDLE) | block |
                   (new_tx_data & (tx_state_q == ST_IDLE));

endmodule

// File: tb/tb_fountain_uart.sv
// Self-checking bench for fountain_uart: randomized frames against a queue-based
// line model, plus directed waveform, handshake, block, glitch and reset cases.
`timescale 1ns/1ps
module tb_fountain_uart;

  localparam int CPB   = 50;
  localparam int FRAME = 10 * CPB;
  // Pin-fall to strobe latency, allowed +/-1 cycle.
  localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       block = 1'b0;
  logic       new_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, new_rx_data;
  logic [7:0] rx_data;
`ifdef UART_FRAMING_ERR_EN
  logic       framing_err;
`endif

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;

  logic [7:0] rx_got[$];
  int         rx_got_cyc[$];
  logic [7:0] tx_seen[$];
  int         tx_fall[$];
  int         tx_stop_bad = 0;
  int         fe_cnt = 0;
  logic [7:0] model_rx_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fountain_uart #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .tx          (tx),
    .block       (block),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data)
`ifdef UART_FRAMING_ERR_EN
    ,
    .framing_err (framing_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 line level k cycles after the accepting edge.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / CPB;
    if (k >= FRAME) return 1'b1;
    if (idx == 0)   return 1'b0;
    if (idx == 9)   return 1'b1;
    return b[idx-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    tx_data     = b;
    new_tx_data = 1'b1;
    tick(1);
    new_tx_data = 1'b0;
  endtask

  always @(negedge clk) begin
    if (new_rx_data) begin
      rx_got.push_back(rx_data);
      rx_got_cyc.push_back(cycle);
    end
`ifdef UART_FRAMING_ERR_EN
    if (framing_err) fe_cnt++;
`endif
  end

  // Passive line decoder: samples each bit of a frame at its centre.
  initial begin : tx_decoder
    logic [7:0] b;
    logic       prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !tx && !rst) begin
        tx_fall.push_back(cycle);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!tx) tx_stop_bad++;
        tx_seen.push_back(b);
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rb, tb_b;
    int fall_cyc, lat, mism, low_cnt, busy_low, guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_new_rx", new_rx_data, 0);
`ifdef UART_FRAMING_ERR_EN
    check("rst_framing_err", framing_err, 0);
`endif
    block = 1'b1;
    #1;
    check("rst_busy_block", tx_busy, 1);
    block = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);

    // Cycle-exact 0xA5 frame
    tx_seen.delete();
    tx_fall.delete();
    tx_data     = 8'hA5;
    new_tx_data = 1'b1;
    @(negedge clk);
    check("busy_in_request", tx_busy, 1);
    @(posedge clk);
    #1;
    new_tx_data = 1'b0;
    mism = 0;
    for (int k = 0; k < FRAME + 10; k++) begin
      @(negedge clk);
      if (tx !== frame_bit(8'hA5, k)) mism++;
      if (k == FRAME - 1) check("busy_last_stop", tx_busy, 1);
      if (k == FRAME)     check("busy_after_frame", tx_busy, 0);
    end
    check("tx_wave_a5", mism, 0);
    check("tx_decode_a5", tx_seen.size() > 0 ? tx_seen[0] : 8'hxx, 8'hA5);
    @(posedge clk);
    #1;

    // RX 0x3C with latency window
    rx_got.delete();
    rx_got_cyc.delete();
    fall_cyc = cycle;
    send_rx(8'h3C, 1'b1);
    tick(20);
    check("rx_3c_count", rx_got.size(), 1);
    check("rx_3c_data", rx_got.size() > 0 ? rx_got[0] : 8'hxx, 8'h3C);
    lat = rx_got_cyc.size() > 0 ? rx_got_cyc[0] - fall_cyc : -100;
    check("rx_3c_latency", (lat >= RX_LAT - 1) && (lat <= RX_LAT + 1), 1);
    model_rx_data = 8'h3C;

    // Glitch rejection, then a clean 0x55
    rx_got.delete();
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(2 * CPB);
    check("glitch_no_strobe", rx_got.size(), 0);
    send_rx(8'h55, 1'b1);
    tick(20);
    check("post_glitch_count", rx_got.size(), 1);
    check("post_glitch_data", rx_got.size() > 0 ? rx_got[0] : 8'hxx, 8'h55);
    model_rx_data = 8'h55;

    // Randomized simultaneous RX and TX
    rx_got.delete();
    tx_seen.delete();
    tx_stop_bad = 0;
    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom);
      tb_b = 8'($urandom);
      exp_rx.push_back(rb);
      exp_tx.push_back(tb_b);
      fork
        send_rx(rb, 1'b1);
        send_tx(tb_b);
      join
      tick(CPB + $urandom_range(1, 30));
      model_rx_data = rb;
    end
    check("rand_rx_count", rx_got.size(), exp_rx.size());
    check("rand_tx_count", tx_seen.size(), exp_tx.size());
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rand_rx_%0d", i), i < rx_got.size() ? rx_got[i] : 8'hxx, exp_rx[i]);
      check($sformatf("rand_tx_%0d", i), i < tx_seen.size() ? tx_seen[i] : 8'hxx, exp_tx[i]);
    end
    check("rand_tx_stop", tx_stop_bad, 0);

    // Handshake: producer requests in the first cycle busy is seen low
    tx_seen.delete();
    tx_fall.delete();
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      @(negedge clk);
      while (tx_busy && guard < 4 * FRAME) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("hs_wait_%0d", i), guard < 4 * FRAME, 1);
      tx_data     = 8'(i + 1);
      new_tx_data = 1'b1;
      @(posedge clk);
      #1;
      new_tx_data = 1'b0;
    end
    tick(FRAME + CPB);
    check("hs_count", tx_seen.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("hs_byte_%0d", i), i < tx_seen.size() ? tx_seen[i] : 8'hxx, 8'(i + 1));
    check("hs_gap_01", tx_fall.size() >= 2 ? tx_fall[1] - tx_fall[0] : 0, FRAME + 1);
    check("hs_gap_12", tx_fall.size() >= 3 ? tx_fall[2] - tx_fall[1] : 0, FRAME + 1);

    // Block: requests while blocked are dropped, not queued
    tx_seen.delete();
    low_cnt  = 0;
    busy_low = 0;
    block    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      new_tx_data = 1'($urandom_range(0, 1));
      tx_data     = 8'($urandom);
      @(negedge clk);
      if (!tx) low_cnt++;
      if (!tx_busy) busy_low++;
      @(posedge clk);
      #1;
    end
    new_tx_data = 1'b0;
    block       = 1'b0;
    check("block_tx_low", low_cnt, 0);
    check("block_busy_low", busy_low, 0);
    low_cnt = 0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    check("block_not_queued", low_cnt, 0);
    check("block_no_frames", tx_seen.size(), 0);
    @(posedge clk);
    #1;

    // Low stop bit on 0x7E
    rx_got.delete();
    fe_cnt = 0;
    send_rx(8'h7E, 1'b0);
    tick(2 * CPB);
`ifdef UART_FRAMING_ERR_EN
    check("fe_pulse", fe_cnt, 1);
    check("fe_no_strobe", rx_got.size(), 0);
    check("fe_data_kept", rx_data, model_rx_data);
`else
    check("stop_low_count", rx_got.size(), 1);
    check("stop_low_data", rx_got.size() > 0 ? rx_got[0] : 8'hxx, 8'h7E);
    model_rx_data = 8'h7E;
`endif
    rx_got.delete();
    rb = 8'($urandom);
    send_rx(rb, 1'b1);
    tick(20);
    check("after_stop_low_data", rx_got.size() == 1 ? rx_got[0] : 8'hxx, rb);

    // Reset in TX bit 4 while an RX frame is in flight
    rx_got.delete();
    fork
      send_rx(8'hFF, 1'b1);
      begin
        send_tx(8'hC3);
        tick(5 * CPB + CPB / 2 - 1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_tx", tx, 1);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_rx_data", rx_data, 8'h00);
      end
    join
    low_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    check("rst_mid_tx_idle", low_cnt, 0);
    check("rst_mid_no_strobe", rx_got.size(), 0);
    @(posedge clk);
    #1;

    // Both directions still work after the mid-frame reset
    rx_got.delete();
    tx_seen.delete();
    rb   = 8'($urandom);
    tb_b = 8'($urandom);
    fork
      send_rx(rb, 1'b1);
      send_tx(tb_b);
    join
    tick(CPB);
    check("post_rst_rx", rx_got.size() == 1 ? rx_got[0] : 8'hxx, rb);
    check("post_rst_tx", tx_seen.size() == 1 ? tx_seen[0] : 8'hxx, tb_b);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
